cnt_seq_ctrl: RTL
=================

# cnt_seq_ctrl

Sequencer for the up/down counter datapath (enable, synchronous load, direction, N-bit data in, N-bit count out). It accepts one counting job at a time over a valid/ready command port. For each job it loads a start value, steps the counter in the requested direction until the count equals an end value, optionally repeats the pass, and then signals completion. It sits between a software/config master and the counter and is the only driver of the counter's control inputs.

## Interface
- N, 8, counter width (same as the counter it drives)
- R, 4, width of the repeat field
- i_clk  in  1  clock; all logic on posedge
- i_rstn  in  1  reset; synchronous and active-low; the counter shares this reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  controller can accept a command
- i_cmd_start  in  N  value loaded at the start of each pass
- i_cmd_end  in  N  terminal count value
- i_cmd_dir  in  1  1 = increment, 0 = decrement
- i_cmd_reps  in  R  extra passes after the first (0 = single pass)
- i_pause  in  1  hold the counter while running
- i_abort  in  1  terminate the current job
- i_cnt_value  in  N  counter's o_result
- o_cnt_en  out  1  counter i_en
- o_cnt_load  out  1  counter i_load
- o_cnt_dir  out  1  counter i_dir
- o_cnt_data  out  N  counter i_data
- o_busy  out  1  job in progress (LOAD or RUN)
- o_done  out  1  one-cycle pulse at job end
- o_aborted  out  1  one-cycle pulse, qualifies o_done when the job ended by abort

## Operation
- **FSM states:** IDLE, LOAD, RUN, DONE. The state register resets to IDLE.
- **IDLE**
  - o_cmd_ready=1.
  - On i_cmd_valid&&o_cmd_ready: register start, end, dir and reps (rep_left=i_cmd_reps), then go to LOAD.
  - i_pause and i_abort are ignored.
- **LOAD** (exactly 1 cycle)
  - o_cnt_en=1, o_cnt_load=1, o_cnt_data=start_r, o_cnt_dir=dir_r.
  - i_pause is ignored.
  - Next state is RUN.
- **RUN**
  - o_cnt_load=0, o_cnt_dir=dir_r.
  - o_cnt_en = !i_pause && (i_cnt_value != end_r) && !i_abort, combinational on the current count.
  - If i_cnt_value==end_r and rep_left==0, go to DONE.
  - If i_cnt_value==end_r and rep_left!=0, decrement rep_left and go to LOAD.
- **DONE** (1 cycle): o_done=1, then go to IDLE.
- **Abort:** i_abort in LOAD or RUN forces o_cnt_en=0 and o_cnt_load=0 that cycle, sets the abort flag, and goes to DONE. DONE then drives o_done=1 and o_aborted=1.
- **Priority in RUN:** abort > end-match > pause.
- **Wrap-around:** counting is modulo 2^N and no special handling exists. The step count per pass is S = (end−start) mod 2^N for increment and (start−end) mod 2^N for decrement.
- **start==end:** S=0 and the pass completes with no count steps.
- **Command while busy:** o_cmd_ready=0; the master holds i_cmd_valid and its payload.
- **Registered outputs:** o_busy=(state∈{LOAD,RUN}), o_done and o_aborted are Moore outputs of DONE.
- **Don't-care:** o_cnt_data equals start_r in every state and is only meaningful when o_cnt_load=1.
- **Reset (i_rstn=0 at a clock edge):**
  - State returns to IDLE and the registered fields and flags clear to 0.
  - While i_rstn=0, all outputs are 0, including o_cmd_ready.
  - After reset: o_cmd_ready=1, everything else 0.
  - A reset mid-job discards the job with no o_done pulse.

## Timing
- t0 is the accept cycle.
- LOAD occurs at t1, and the counter shows start at t2.
- With no pause: each pass takes S+2 cycles (LOAD plus S+1 RUN cycles), and o_done is high at t0 + (R+1)(S+2) + 1, where R is i_cmd_reps.
- Each cycle with i_pause=1 in RUN (and count≠end) adds 1 cycle, and the count stays stable during it.
- Abort sampled in cycle ta gives o_done/o_aborted at ta+1 and o_cmd_ready=1 at ta+2.
- The earliest next accept is the cycle after DONE.

## Test plan
- **Single pass up:** N=8, start=10, end=13, dir=1, reps=0.
  - Count 10,11,12,13 at t2..t5.
  - o_cnt_en=1 at t1..t4 and 0 at t5.
  - o_done at t6 with o_aborted=0.
- **Wrap up:** start=254, end=1, dir=1.
  - Count 254,255,0,1 at t2..t5.
  - o_done at t6.
- **Wrap down:** start=1, end=254, dir=0.
  - Count 1,0,255,254 at t2..t5.
  - o_done at t6.
- **Zero steps, repeated:** start=end=5, reps=2.
  - o_cnt_load pulses at t1, t3, t5.
  - o_cnt_en is never 1 in RUN.
  - o_done at t7.
- **Pause:** job from the first test with i_pause=1 at t3..t4.
  - Count holds 11 through t5, reaches 13 at t7.
  - o_done at t8.
  - A second command offered at t4 is held off until o_cmd_ready=1 at t9.
- **Abort and reset:**
  - Abort: i_abort=1 at t3 of the first test gives o_cnt_en=0 at t3, o_done=o_aborted=1 at t4, and o_cmd_ready=1 at t5.
  - Reset: repeat the job with i_rstn=0 at t3. All outputs are 0 during reset and no o_done pulse occurs. After release, o_cmd_ready=1 and the counter reads 0.

Source files
------------

// File: rtl/cnt_seq_ctrl_if.sv
// Command port of the counter sequencer: one job per
// valid/ready transfer, payload held by the master until accepted.
interface cnt_seq_ctrl_if #(
  parameter int N = 8,
  parameter int R = 4
);
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [N-1:0] i_cmd_start;
  logic [N-1:0] i_cmd_end;
  logic         i_cmd_dir;
  logic [R-1:0] i_cmd_reps;

  modport master (
    output i_cmd_valid,
    output i_cmd_start,
    output i_cmd_end,
    output i_cmd_dir,
    output i_cmd_reps,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd_start,
    input  i_cmd_end,
    input  i_cmd_dir,
    input  i_cmd_reps,
    output o_cmd_ready
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Job sequencer for the up/down counter: load start, step to
// end, repeat the pass rep times, then pulse done.
module cnt_seq_ctrl #(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  cnt_seq_ctrl_if.slave cmd,
  input  logic         i_pause,
  input  logic         i_abort,
  input  logic [N-1:0] i_cnt_value,
  output logic         o_cnt_en,
  output logic         o_cnt_load,
  output logic         o_cnt_dir,
  output logic [N-1:0] o_cnt_data,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_aborted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] end_q, end_d;
  logic         dir_q, dir_d;
  logic [R-1:0] rep_q, rep_d;
  logic         abort_q, abort_d;

  logic is_idle;
  logic is_load;
  logic is_run;
  logic is_done;
  logic at_end;
  logic accept;

  assign is_idle = (state_q == S_IDLE);
  assign is_load = (state_q == S_LOAD);
  assign is_run  = (state_q == S_RUN);
  assign is_done = (state_q == S_DONE);

  assign at_end = (i_cnt_value == end_q);
  assign accept = is_idle && cmd.i_cmd_valid;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    dir_d   = dir_q;
    rep_d   = rep_q;
    abort_d = abort_q;
    unique case (1'b1)
      is_idle: begin
        if (accept) begin
          start_d = cmd.i_cmd_start;
          end_d   = cmd.i_cmd_end;
          dir_d   = cmd.i_cmd_dir;
          rep_d   = cmd.i_cmd_reps;
          abort_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      is_load: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      is_run: begin
        // abort wins over end-match, end-match over pause
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (at_end) begin
          if (rep_q == '0) begin
            state_d = S_DONE;
          end else begin
            rep_d   = rep_q - R'(1);
            state_d = S_LOAD;
          end
        end
      end
      is_done: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      dir_q   <= 1'b0;
      rep_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
      rep_q   <= rep_d;
      abort_q <= abort_d;
    end
  end

  // every output is forced low while reset is held
  logic run_step;

  assign run_step = is_run && !i_pause && !at_end;

  assign cmd.o_cmd_ready = i_rstn && is_idle;

  assign o_cnt_load = i_rstn && is_load && !i_abort;
  assign o_cnt_en   = i_rstn && !i_abort
                      && (is_load || run_step);
  assign o_cnt_dir  = i_rstn && dir_q;
  assign o_cnt_data = i_rstn ? start_q : '0;

  assign o_busy    = i_rstn && (is_load || is_run);
  assign o_done    = i_rstn && is_done;
  assign o_aborted = i_rstn && is_done && abort_q;

endmodule
